// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (see load_store_unit.sv).
package lsu_pkg;

    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} lsu_size_t;

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} lsu_state_t;

    // Number of bytes touched by an access of the given size.
    function automatic logic [3:0] size_bytes(input lsu_size_t sz);
        logic [3:0] n;
        case (sz)
            SZ_B:    n = 4'd1;
            SZ_H:    n = 4'd2;
            SZ_W:    n = 4'd4;
            SZ_D:    n = 4'd8;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: load extract/extend and store merge
// within one little-endian 64-bit doubleword.
import lsu_pkg::*;

module lsu_lane_align (
    input  logic [2:0]  off,
    input  lsu_size_t   size,
    input  logic        is_unsigned,
    input  logic [63:0] rdata,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [63:0] store_data
);

    logic [5:0]  shamt_s;
    logic [63:0] shifted_s;
    logic [63:0] lane_mask_s;

    assign shamt_s   = {off, 3'b000};
    assign shifted_s = rdata >> shamt_s;

    // Load path: keep the addressed bytes and extend from the top kept bit.
    always_comb begin
        load_data = shifted_s;
        case (size)
            SZ_B:    load_data = is_unsigned ? {56'd0, shifted_s[7:0]}
                                             : {{56{shifted_s[7]}}, shifted_s[7:0]};
            SZ_H:    load_data = is_unsigned ? {48'd0, shifted_s[15:0]}
                                             : {{48{shifted_s[15]}}, shifted_s[15:0]};
            SZ_W:    load_data = is_unsigned ? {32'd0, shifted_s[31:0]}
                                             : {{32{shifted_s[31]}}, shifted_s[31:0]};
            SZ_D:    load_data = shifted_s;
            default: load_data = shifted_s;
        endcase
    end

    // Store path: mask of the bytes being replaced, before positioning.
    always_comb begin
        lane_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
        case (size)
            SZ_B:    lane_mask_s = 64'h0000_0000_0000_00FF;
            SZ_H:    lane_mask_s = 64'h0000_0000_0000_FFFF;
            SZ_W:    lane_mask_s = 64'h0000_0000_FFFF_FFFF;
            SZ_D:    lane_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
            default: lane_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    assign store_data = (rdata & ~(lane_mask_s << shamt_s)) |
                        ((wdata & lane_mask_s) << shamt_s);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the multicycle datapath and the 64-bit data memory.
// Narrow stores are done as read-modify-write of the enclosing doubleword.
// Optional feature: define LSU_MISALIGN_TRAP_EN to answer misaligned requests
// with resp_err instead of silently aligning the offset down.
import lsu_pkg::*;

module load_store_unit #(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic              mem_wr,
    input  logic [63:0]       mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    lsu_state_t        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              write_r;
    lsu_size_t         size_r;
    logic              unsigned_r;
    logic [2:0]        off_r;
    logic [63:0]       wdata_r;
    logic              resp_valid_r;
    logic [63:0]       resp_rdata_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [63:0]       mem_wdata_r;
    logic              mem_wr_r;

    lsu_size_t         req_size_s;
    logic [2:0]        low_mask_s;
    logic [2:0]        off_cap_s;
    logic [63:0]       load_data_s;
    logic [63:0]       store_data_s;

    assign req_size_s = lsu_size_t'(req_size);
    assign low_mask_s = 3'(size_bytes(req_size_s) - 4'd1);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_s;
    logic resp_err_r;
    assign misalign_s = |(req_addr[2:0] & low_mask_s);
    assign off_cap_s  = req_addr[2:0];
    assign resp_err   = resp_err_r;
`else
    // Offset bits below the access size are dropped so the access is aligned.
    assign off_cap_s  = req_addr[2:0] & ~low_mask_s;
    assign resp_err   = 1'b0;
`endif

    assign req_ready  = (state_r == IDLE);
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_wr     = mem_wr_r;

    lsu_lane_align u_align (
        .off         (off_r),
        .size        (size_r),
        .is_unsigned (unsigned_r),
        .rdata       (mem_rdata),
        .wdata       (wdata_r),
        .load_data   (load_data_s),
        .store_data  (store_data_s)
    );

    // Request FSM with latency counter and registered memory/response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            write_r      <= 1'b0;
            size_r       <= SZ_B;
            unsigned_r   <= 1'b0;
            off_r        <= 3'd0;
            wdata_r      <= 64'd0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 64'd0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= 64'd0;
            mem_wr_r     <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            resp_err_r   <= 1'b0;
`endif
        end else begin
            resp_valid_r <= 1'b0;
            mem_wr_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        write_r    <= req_write;
                        size_r     <= req_size_s;
                        unsigned_r <= req_unsigned;
                        off_r      <= off_cap_s;
                        wdata_r    <= req_wdata;
                        mem_addr_r <= {req_addr[ADDR_W-1:3], 3'b000};
                        cnt_r      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                        resp_err_r <= misalign_s;
                        if (misalign_s) begin
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                        end else
`endif
                        if (req_write && (req_size_s == SZ_D)) begin
                            state_r     <= WRITE;
                            mem_wr_r    <= 1'b1;
                            mem_wdata_r <= req_wdata;
                        end else begin
                            state_r <= READ;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    if (cnt_r == CNT_LAST) begin
                        if (write_r) begin
                            state_r     <= WRITE;
                            mem_wr_r    <= 1'b1;
                            mem_wdata_r <= store_data_s;
                        end else begin
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_rdata_r <= load_data_s;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                WRITE: begin
                    state_r      <= RESP;
                    resp_valid_r <= 1'b1;
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (MEM_LATENCY=1 and =3).
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid, req_valid3;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    logic        req_ready, resp_valid, resp_err, mem_wr;
    logic [63:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        req_ready3, resp_valid3, resp_err3, mem_wr3;
    logic [63:0] resp_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

    logic [63:0] mem [0:15];
    logic        pre_en;
    logic [3:0]  pre_idx;
    logic [63:0] pre_val;

    int n_cmp, n_bad;
    int resp_cyc, resp_cnt, wr_cyc, wr_cnt;
    logic [63:0] rdata_at, wdata_at;
    logic        err_at;
    logic        ready_hist [0:12];

    load_store_unit #(.MEM_LATENCY(1), .ADDR_W(64)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.MEM_LATENCY(3), .ADDR_W(64)) dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid3),
        .resp_rdata(resp_rdata3), .resp_err(resp_err3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_wr(mem_wr3), .mem_rdata(mem_rdata3)
    );

    assign mem_rdata  = mem[mem_addr[6:3]];
    assign mem_rdata3 = mem[mem_addr3[6:3]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: preload port from the bench, write port from the L=1 unit.
    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        else if (mem_wr) mem[mem_addr[6:3]] <= mem_wdata;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [3:0] idx, input logic [63:0] val);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Issue one request on the selected unit and record 12 cycles of activity.
    task automatic run_op(input bit sel, input logic w, input logic [1:0] sz,
                          input logic u, input logic [63:0] a, input logic [63:0] wd);
        @(negedge clk);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        if (sel) req_valid3 = 1'b1; else req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_valid3 = 1'b0;
        resp_cyc = -1; resp_cnt = 0; wr_cyc = -1; wr_cnt = 0;
        rdata_at = 64'd0; wdata_at = 64'd0; err_at = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(negedge clk);
            if (sel ? resp_valid3 : resp_valid) begin
                resp_cnt++;
                if (resp_cyc < 0) begin
                    resp_cyc = c;
                    rdata_at = sel ? resp_rdata3 : resp_rdata;
                    err_at   = sel ? resp_err3 : resp_err;
                end
            end
            if (sel ? mem_wr3 : mem_wr) begin
                wr_cnt++;
                if (wr_cyc < 0) begin
                    wr_cyc   = c;
                    wdata_at = sel ? mem_wdata3 : mem_wdata;
                end
            end
            ready_hist[c] = sel ? req_ready3 : req_ready;
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset = 1'b1; req_valid = 1'b0; req_valid3 = 1'b0;
        req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 64'd0; req_wdata = 64'd0;
        pre_en = 1'b0; pre_idx = 4'd0; pre_val = 64'd0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pre_en = 1'b1; pre_idx = 4'(i); pre_val = 64'd0;
        end
        @(negedge clk);
        pre_en = 1'b0;
        check_eq("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check_eq("rst_resp_rdata", resp_rdata, 64'd0);
        check_eq("rst_mem_wr", {63'd0, mem_wr}, 64'd0);
        check_eq("rst_mem_addr", mem_addr, 64'd0);
        check_eq("rst_mem_wdata", mem_wdata, 64'd0);
        check_eq("rst_req_ready", {63'd0, req_ready}, 64'd1);
        reset = 1'b0;
        preload(4'd2, 64'h8877665544332211);

        // 1: doubleword load
        run_op(1'b0, 1'b0, 2'd3, 1'b0, 64'h10, 64'd0);
        check_eq("ld_data", rdata_at, 64'h8877665544332211);
        check_eq("ld_cycle", 64'(resp_cyc), 64'd2);
        check_eq("ld_pulses", 64'(resp_cnt), 64'd1);
        check_eq("ld_no_wr", 64'(wr_cnt), 64'd0);

        // 2: narrow loads with sign / zero extension
        run_op(1'b0, 1'b0, 2'd0, 1'b0, 64'h17, 64'd0);
        check_eq("lb_data", rdata_at, 64'hFFFFFFFFFFFFFF88);
        run_op(1'b0, 1'b0, 2'd0, 1'b1, 64'h17, 64'd0);
        check_eq("lbu_data", rdata_at, 64'h0000000000000088);
        run_op(1'b0, 1'b0, 2'd2, 1'b0, 64'h14, 64'd0);
        check_eq("lw_data", rdata_at, 64'hFFFFFFFF88776655);
        run_op(1'b0, 1'b0, 2'd1, 1'b1, 64'h12, 64'd0);
        check_eq("lhu_data", rdata_at, 64'h0000000000004433);

        // 3: halfword store, read-modify-write
        run_op(1'b0, 1'b1, 2'd1, 1'b0, 64'h12, 64'h000000000000ABCD);
        check_eq("sh_wr_cycle", 64'(wr_cyc), 64'd2);
        check_eq("sh_wr_count", 64'(wr_cnt), 64'd1);
        check_eq("sh_wdata", wdata_at, 64'h88776655ABCD2211);
        check_eq("sh_resp_cycle", 64'(resp_cyc), 64'd3);
        check_eq("sh_rdata_kept", rdata_at, 64'h0000000000004433);
        check_eq("sh_mem", mem[2], 64'h88776655ABCD2211);

        // 4: doubleword store, no read phase
        run_op(1'b0, 1'b1, 2'd3, 1'b0, 64'h20, 64'h0123456789ABCDEF);
        check_eq("sd_wr_cycle", 64'(wr_cyc), 64'd1);
        check_eq("sd_wr_count", 64'(wr_cnt), 64'd1);
        check_eq("sd_resp_cycle", 64'(resp_cyc), 64'd2);
        check_eq("sd_ready_c1", {63'd0, ready_hist[1]}, 64'd0);
        check_eq("sd_ready_c2", {63'd0, ready_hist[2]}, 64'd0);
        check_eq("sd_ready_c3", {63'd0, ready_hist[3]}, 64'd1);
        check_eq("sd_mem", mem[4], 64'h0123456789ABCDEF);

        // 5: reset during the write phase of a byte store
        @(negedge clk);
        req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 64'h20; req_wdata = 64'h5A; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("sb_wr_before_rst", {63'd0, mem_wr}, 64'd1);
        check_eq("sb_wdata", mem_wdata, 64'h0123456789ABCD5A);
        #1 reset = 1'b1;
        #1;
        check_eq("rst_async_wr", {63'd0, mem_wr}, 64'd0);
        check_eq("rst_async_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        resp_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid) resp_cnt++;
        end
        check_eq("rst_no_resp", 64'(resp_cnt), 64'd0);
        check_eq("rst_mem_kept", mem[4], 64'h0123456789ABCDEF);
        check_eq("rst_ready_after", {63'd0, req_ready}, 64'd1);

        // 6: misaligned word load
        run_op(1'b0, 1'b0, 2'd2, 1'b0, 64'h13, 64'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        check_eq("mis_resp_cycle", 64'(resp_cyc), 64'd1);
        check_eq("mis_err", {63'd0, err_at}, 64'd1);
        check_eq("mis_no_wr", 64'(wr_cnt), 64'd0);
        check_eq("mis_rdata_kept", rdata_at, 64'd0);
`else
        check_eq("mis_data", rdata_at, 64'hFFFFFFFFABCD2211);
        check_eq("mis_err", {63'd0, err_at}, 64'd0);
        check_eq("mis_resp_cycle", 64'(resp_cyc), 64'd2);
`endif

        // 7: longer memory latency
        run_op(1'b1, 1'b0, 2'd3, 1'b0, 64'h10, 64'd0);
        check_eq("l3_resp_cycle", 64'(resp_cyc), 64'd4);
        check_eq("l3_data", rdata_at, 64'h88776655ABCD2211);
        check_eq("l3_ready_c3", {63'd0, ready_hist[3]}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
